// File: rtl/nn_host_driver_if.sv
// Network-side bus of nn_host_driver: control pins, input-read port and output-write port.
// The master modport belongs to the host driver and the slave modport belongs to the network.
interface nn_host_driver_if #(
    parameter int DATA_W = 8,
    parameter int N_IN   = 2,
    parameter int N_OUT  = 1
);
    localparam int AW_IN  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int AW_OUT = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                     net_rst;
    logic                     net_fill;
    logic                     net_ack_fill;
    logic                     net_req;
    logic                     net_ack_network;
    logic                     net_rd_en;
    logic [AW_IN-1:0]         net_rd_addr;
    logic signed [DATA_W-1:0] net_in_data;
    logic                     net_wr_en;
    logic [AW_OUT-1:0]        net_wr_addr;
    logic signed [DATA_W-1:0] net_wr_data;

    modport master (
        output net_rst, net_fill, net_req, net_in_data,
        input  net_ack_fill, net_ack_network, net_rd_en, net_rd_addr,
               net_wr_en, net_wr_addr, net_wr_data
    );

    modport slave (
        input  net_rst, net_fill, net_req, net_in_data,
        output net_ack_fill, net_ack_network, net_rd_en, net_rd_addr,
               net_wr_en, net_wr_addr, net_wr_data
    );
endinterface

// File: rtl/nn_host_driver.sv
// Host-side driver for one network instance: owns the input/result buffers and sequences
// network reset, input fill and the inference request, with a cycle timeout on fill+run.
module nn_host_driver #(
    parameter int DATA_W  = 8,
    parameter int N_IN    = 2,
    parameter int N_OUT   = 1,
    parameter int TIMEOUT = 1024,
    localparam int AW_IN  = (N_IN  > 1) ? $clog2(N_IN)  : 1,
    localparam int AW_OUT = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     host_wr_en,
    input  logic [AW_IN-1:0]         host_wr_addr,
    input  logic signed [DATA_W-1:0] host_wr_data,
    input  logic                     start,
    input  logic [AW_OUT-1:0]        host_rd_addr,
    output logic signed [DATA_W-1:0] host_rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [N_OUT-1:0]         out_mask,
    nn_host_driver_if.master         net
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, RST_NET, FILL, RUN, DONE} state_t;

    state_t                   state;
    state_t                   state_nx;
    logic                     rst_phase;
    logic [CW-1:0]            tmo_cnt;
    logic signed [DATA_W-1:0] in_buf  [N_IN];
    logic signed [DATA_W-1:0] out_buf [N_OUT];

    logic host_open;
    logic capture;
    logic launch;
    logic tmo_hit;
    logic net_rst_c;
    logic net_fill_c;
    logic net_req_c;

    assign host_open = (state == IDLE) || (state == DONE);
    assign capture   = (state == FILL) || (state == RUN);
    assign launch    = host_open && start;
    assign tmo_hit   = capture && (tmo_cnt == CW'(TIMEOUT - 1));

    // NOTE: every output of a combinational block gets a default before the case, so no
    // path through it leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        done       = 1'b0;
        net_rst_c  = rst;
        net_fill_c = 1'b0;
        net_req_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = RST_NET;
            end
            RST_NET: begin
                busy      = 1'b1;
                net_rst_c = 1'b1;
                if (rst_phase) state_nx = FILL;
            end
            FILL: begin
                busy       = 1'b1;
                net_fill_c = 1'b1;
                if (tmo_hit)               state_nx = DONE;
                else if (net.net_ack_fill) state_nx = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                net_req_c = 1'b1;
                if (tmo_hit || net.net_ack_network) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nx = RST_NET;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign net.net_rst  = net_rst_c;
    assign net.net_fill = net_fill_c;
    assign net.net_req  = net_req_c;

    // NOTE: the buffers are reset like any other register so a host read after reset is
    // deterministic; this rules out block-RAM mapping, which these tiny buffers do not need.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rst_phase <= 1'b0;
            tmo_cnt   <= '0;
            err       <= 1'b0;
            out_mask  <= '0;
            for (int i = 0; i < N_IN; i++)  in_buf[i]  <= '0;
            for (int i = 0; i < N_OUT; i++) out_buf[i] <= '0;
        end else begin
            state     <= state_nx;
            // Two-cycle network reset: phase 0 then phase 1, cleared outside RST_NET.
            rst_phase <= (state == RST_NET) ? ~rst_phase : 1'b0;

            if (launch) begin
                err      <= 1'b0;
                out_mask <= '0;
                tmo_cnt  <= '0;
            end else if (capture) begin
                if (tmo_hit) err     <= 1'b1;
                else         tmo_cnt <= tmo_cnt + CW'(1);
            end

            // Address matching drops out-of-range indices without a separate bound check.
            if (host_open && host_wr_en) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (host_wr_addr == AW_IN'(i)) in_buf[i] <= host_wr_data;
                end
            end

            if (capture && net.net_wr_en) begin
                for (int i = 0; i < N_OUT; i++) begin
                    if (net.net_wr_addr == AW_OUT'(i)) begin
                        out_buf[i]  <= net.net_wr_data;
                        out_mask[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // The network samples the read data a cycle after its strobe, so this port is
    // answered combinationally every cycle regardless of net_rd_en.
    always_comb begin
        net.net_in_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (net.net_rd_addr == AW_IN'(i)) net.net_in_data = in_buf[i];
        end
    end

    always_comb begin
        host_rd_data = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (host_rd_addr == AW_OUT'(i)) host_rd_data = out_buf[i];
        end
    end
endmodule

// File: tb/tb_nn_host_driver.sv
// Directed bench for nn_host_driver: the bench plays the network by hand and compares
// every observation against hand-computed values.
module tb_nn_host_driver;
    localparam int DATA_W  = 8;
    localparam int N_IN    = 3;
    localparam int N_OUT   = 1;
    localparam int TIMEOUT = 16;
    localparam int AW_IN   = 2;
    localparam int AW_OUT  = 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     host_wr_en;
    logic [AW_IN-1:0]         host_wr_addr;
    logic signed [DATA_W-1:0] host_wr_data;
    logic                     start;
    logic [AW_OUT-1:0]        host_rd_addr;
    logic signed [DATA_W-1:0] host_rd_data;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [N_OUT-1:0]         out_mask;

    int n_cmp = 0;
    int n_bad = 0;
    int rc;
    int lat;
    logic [N_OUT-1:0] m0;

    nn_host_driver_if #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT)) nb ();

    nn_host_driver #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .host_wr_en   (host_wr_en),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .start        (start),
        .host_rd_addr (host_rd_addr),
        .host_rd_data (host_rd_data),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .out_mask     (out_mask),
        .net          (nb.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start and plays the network reset phase; returns net_rst cycles, cycles until
    // net_fill, and out_mask right after the start edge. Bounded at 10 cycles.
    task automatic launch(output int rst_cyc, output int cyc, output logic [N_OUT-1:0] mask0);
        rst_cyc = 0;
        start   = 1'b1;
        step();
        start   = 1'b0;
        cyc     = 1;
        mask0   = out_mask;
        while (!nb.net_fill && cyc < 10) begin
            if (nb.net_rst) begin
                rst_cyc++;
                nb.net_ack_fill    = 1'b0;
                nb.net_ack_network = 1'b0;
            end
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (out_mask !== 1'b0) begin n_bad++; $display("FAIL reset_mask: got %b want 0", out_mask); end
        n_cmp++; if (nb.net_fill !== 1'b0 || nb.net_req !== 1'b0) begin
            n_bad++; $display("FAIL reset_fill_req: got fill=%b req=%b want 0/0", nb.net_fill, nb.net_req); end
        n_cmp++; if (nb.net_rst !== 1'b1) begin n_bad++; $display("FAIL reset_net_rst: got %b want 1", nb.net_rst); end
        n_cmp++; if (host_rd_data !== 8'sd0) begin n_bad++; $display("FAIL reset_rd_data: got %0d want 0", host_rd_data); end
        rst = 1'b0;
        step();
        n_cmp++; if (nb.net_rst !== 1'b0) begin n_bad++; $display("FAIL idle_net_rst: got %b want 0", nb.net_rst); end
    endtask

    task automatic test_basic();
        host_wr_en = 1'b1; host_wr_addr = 2'd0; host_wr_data = 8'sd5;  step();
        host_wr_addr = 2'd1; host_wr_data = -8'sd3; step();
        host_wr_en = 1'b0;
        launch(rc, lat, m0);
        n_cmp++; if (rc !== 2) begin n_bad++; $display("FAIL basic_net_rst_cycles: got %0d want 2", rc); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL basic_fill_latency: got %0d want 3", lat); end
        nb.net_rd_en = 1'b1; nb.net_rd_addr = 2'd0; #1;
        n_cmp++; if (nb.net_in_data !== 8'sd5) begin n_bad++; $display("FAIL basic_read0: got %0d want 5", nb.net_in_data); end
        step();
        nb.net_rd_addr = 2'd1; #1;
        n_cmp++; if (nb.net_in_data !== -8'sd3) begin n_bad++; $display("FAIL basic_read1: got %0d want -3", nb.net_in_data); end
        nb.net_rd_en = 1'b0;
        nb.net_ack_fill = 1'b1;
        step();
        n_cmp++; if (nb.net_req !== 1'b1 || nb.net_fill !== 1'b0) begin
            n_bad++; $display("FAIL basic_run: got req=%b fill=%b want 1/0", nb.net_req, nb.net_fill); end
        nb.net_wr_en = 1'b1; nb.net_wr_addr = 1'b0; nb.net_wr_data = 8'sd2;
        step();
        nb.net_wr_en = 1'b0;
        nb.net_ack_network = 1'b1;
        step();
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || nb.net_req !== 1'b0) begin
            n_bad++; $display("FAIL basic_done: got done=%b busy=%b req=%b want 1/0/0", done, busy, nb.net_req); end
        host_rd_addr = 1'b0; #1;
        n_cmp++; if (host_rd_data !== 8'sd2) begin n_bad++; $display("FAIL basic_result: got %0d want 2", host_rd_data); end
        n_cmp++; if (out_mask !== 1'b1) begin n_bad++; $display("FAIL basic_mask: got %b want 1", out_mask); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b want 0", err); end
    endtask

    // Second run from DONE; also both acks arrive together in FILL.
    task automatic test_back_to_back();
        host_wr_en = 1'b1; host_wr_addr = 2'd0; host_wr_data = 8'sd127; step();
        host_wr_addr = 2'd1; host_wr_data = -8'sd128; step();
        host_wr_en = 1'b0;
        launch(rc, lat, m0);
        n_cmp++; if (rc !== 2) begin n_bad++; $display("FAIL b2b_net_rst_cycles: got %0d want 2", rc); end
        n_cmp++; if (m0 !== 1'b0) begin n_bad++; $display("FAIL b2b_mask_clear: got %b want 0", m0); end
        nb.net_rd_addr = 2'd0; #1;
        n_cmp++; if (nb.net_in_data !== 8'sd127) begin n_bad++; $display("FAIL b2b_read0: got %0d want 127", nb.net_in_data); end
        nb.net_rd_addr = 2'd1; #1;
        n_cmp++; if (nb.net_in_data !== -8'sd128) begin n_bad++; $display("FAIL b2b_read1: got %0d want -128", nb.net_in_data); end
        nb.net_wr_en = 1'b1; nb.net_wr_addr = 1'b0; nb.net_wr_data = -8'sd1;
        nb.net_ack_fill = 1'b1; nb.net_ack_network = 1'b1;
        step();
        nb.net_wr_en = 1'b0;
        n_cmp++; if (nb.net_req !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL b2b_coincide_run: got req=%b done=%b want 1/0", nb.net_req, done); end
        step();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_coincide_done: got %b want 1", done); end
        n_cmp++; if (host_rd_data !== -8'sd1) begin n_bad++; $display("FAIL b2b_result: got %0d want -1", host_rd_data); end
        n_cmp++; if (out_mask !== 1'b1) begin n_bad++; $display("FAIL b2b_mask: got %b want 1", out_mask); end
    endtask

    task automatic test_timeout();
        int n;
        logic req_seen;
        launch(rc, lat, m0);
        nb.net_ack_fill = 1'b1;
        n = 0;
        req_seen = 1'b0;
        while (!done && n < 40) begin
            step();
            n++;
            if (n == 1) req_seen = nb.net_req;
        end
        n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL tmo_cycles: got %0d want 16", n); end
        n_cmp++; if (req_seen !== 1'b1) begin n_bad++; $display("FAIL tmo_req_in_run: got %b want 1", req_seen); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL tmo_err: got %b want 1", err); end
        n_cmp++; if (nb.net_req !== 1'b0 || nb.net_fill !== 1'b0 || nb.net_rst !== 1'b0) begin
            n_bad++; $display("FAIL tmo_pins: got req=%b fill=%b rst=%b want 0/0/0", nb.net_req, nb.net_fill, nb.net_rst); end
        n_cmp++; if (host_rd_data !== -8'sd1) begin n_bad++; $display("FAIL tmo_buf_kept: got %0d want -1", host_rd_data); end
        n_cmp++; if (out_mask !== 1'b0) begin n_bad++; $display("FAIL tmo_mask: got %b want 0", out_mask); end
    endtask

    task automatic test_out_of_range();
        launch(rc, lat, m0);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL oor_err_cleared: got %b want 0", err); end
        nb.net_rd_en = 1'b1; nb.net_rd_addr = 2'd3; #1;
        n_cmp++; if (nb.net_in_data !== 8'sd0) begin n_bad++; $display("FAIL oor_read3: got %0d want 0", nb.net_in_data); end
        nb.net_rd_en = 1'b0;
        nb.net_wr_en = 1'b1; nb.net_wr_addr = 1'b1; nb.net_wr_data = 8'sd55;
        step();
        nb.net_wr_en = 1'b0;
        n_cmp++; if (out_mask !== 1'b0) begin n_bad++; $display("FAIL oor_mask: got %b want 0", out_mask); end
        nb.net_ack_fill = 1'b1; nb.net_ack_network = 1'b1;
        step();
        step();
        n_cmp++; if (done !== 1'b1 || host_rd_data !== -8'sd1) begin
            n_bad++; $display("FAIL oor_done_result: got done=%b data=%0d want 1/-1", done, host_rd_data); end
        nb.net_wr_en = 1'b1; nb.net_wr_addr = 1'b0; nb.net_wr_data = 8'sd9;
        step();
        nb.net_wr_en = 1'b0;
        n_cmp++; if (host_rd_data !== -8'sd1 || out_mask !== 1'b0) begin
            n_bad++; $display("FAIL oor_write_in_done: got data=%0d mask=%b want -1/0", host_rd_data, out_mask); end
    endtask

    task automatic test_busy_ignore();
        int busy_seen;
        host_wr_en = 1'b1; host_wr_addr = 2'd0; host_wr_data = 8'sd7; step();
        host_wr_en = 1'b0;
        launch(rc, lat, m0);
        host_wr_en = 1'b1; host_wr_addr = 2'd0; host_wr_data = 8'sd100;
        step();
        host_wr_en = 1'b0;
        nb.net_rd_addr = 2'd0; #1;
        n_cmp++; if (nb.net_in_data !== 8'sd7) begin n_bad++; $display("FAIL busy_write_dropped: got %0d want 7", nb.net_in_data); end
        nb.net_ack_fill = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (nb.net_req !== 1'b1 || nb.net_rst !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL busy_start_ignored: got req=%b rst=%b busy=%b want 1/0/1", nb.net_req, nb.net_rst, busy); end
        nb.net_wr_en = 1'b1; nb.net_wr_addr = 1'b0; nb.net_wr_data = 8'sd11;
        nb.net_ack_network = 1'b1;
        step();
        nb.net_wr_en = 1'b0;
        busy_seen = 0;
        repeat (4) begin
            step();
            if (busy) busy_seen++;
        end
        n_cmp++; if (busy_seen !== 0 || done !== 1'b1) begin
            n_bad++; $display("FAIL busy_single_done: got busy_cycles=%0d done=%b want 0/1", busy_seen, done); end
        n_cmp++; if (host_rd_data !== 8'sd11) begin n_bad++; $display("FAIL busy_result: got %0d want 11", host_rd_data); end
    endtask

    task automatic test_rst_mid_fill();
        launch(rc, lat, m0);
        rst = 1'b1;
        step();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || nb.net_fill !== 1'b0 || nb.net_rst !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_pins: got busy=%b done=%b fill=%b rst=%b want 0/0/0/1",
                              busy, done, nb.net_fill, nb.net_rst); end
        nb.net_rd_addr = 2'd0; #1;
        n_cmp++; if (host_rd_data !== 8'sd0 || nb.net_in_data !== 8'sd0 || out_mask !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_bufs: got out=%0d in=%0d mask=%b want 0/0/0",
                              host_rd_data, nb.net_in_data, out_mask); end
        rst = 1'b0;
        step();
        // Write and start in the same IDLE cycle: the run must see the new sample.
        host_wr_en = 1'b1; host_wr_addr = 2'd1; host_wr_data = 8'sd42;
        launch(rc, lat, m0);
        host_wr_en = 1'b0;
        nb.net_rd_addr = 2'd1; #1;
        n_cmp++; if (nb.net_in_data !== 8'sd42) begin n_bad++; $display("FAIL same_cycle_write: got %0d want 42", nb.net_in_data); end
        nb.net_ack_fill = 1'b1; nb.net_ack_network = 1'b1;
        step();
        step();
        n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin
            n_bad++; $display("FAIL same_cycle_done: got done=%b err=%b want 1/0", done, err); end
    endtask

    initial begin
        rst = 1'b1; host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0;
        start = 1'b0; host_rd_addr = '0;
        nb.net_ack_fill = 1'b0; nb.net_ack_network = 1'b0; nb.net_rd_en = 1'b0;
        nb.net_rd_addr = '0; nb.net_wr_en = 1'b0; nb.net_wr_addr = '0; nb.net_wr_data = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_out_of_range();
        test_busy_ignore();
        test_rst_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end
endmodule
